// File: rtl/mio_bus_arbiter.sv
// Two-master (CPU priority, DMA anti-starvation) arbiter that sequences one memory/IO bus cycle at a time.
// Optional bus-timeout abort is compiled in when MIO_ARB_TIMEOUT_EN is defined.
module mio_bus_arbiter #(
  parameter int unsigned DEV_MAX_WAIT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        MIO_ready,
  input  logic        dev_req,
  input  logic        dev_we,
  input  logic [31:0] dev_addr,
  input  logic [31:0] dev_wdata,
  output logic [31:0] dev_rdata,
  output logic        dev_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        grant_dev,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DEV = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam int unsigned WAIT_W = $clog2(DEV_MAX_WAIT + 1);

  if (DEV_MAX_WAIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mio_bus_arbiter: DEV_MAX_WAIT and TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_sat;
  logic              cpu_win;
  logic              dev_win;
  logic              txn_done;
  logic              txn_abort;

  assign wait_sat = (wait_cnt == WAIT_W'(DEV_MAX_WAIT));

`ifdef MIO_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // tmo_cnt holds the number of busy cycles already spent; the last allowed one aborts.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cpu_win    = 1'b0;
    dev_win    = 1'b0;
    txn_done   = 1'b0;
    txn_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dev_req && (!cpu_req || wait_sat)) begin
          dev_win    = 1'b1;
          state_next = BUSY_DEV;
        end else if (cpu_req) begin
          cpu_win    = 1'b1;
          state_next = BUSY_CPU;
        end
      end
      BUSY_CPU, BUSY_DEV: begin
        if (mem_ack) begin
          txn_done   = 1'b1;
          state_next = RESP;
        end
`ifdef MIO_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          txn_abort  = 1'b1;
          state_next = RESP;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
      dev_rdata <= 32'h0;
      MIO_ready <= 1'b0;
      dev_ready <= 1'b0;
      grant_dev <= 1'b0;
    end else begin
      MIO_ready <= 1'b0;
      dev_ready <= 1'b0;

      // Request fields are captured at grant, so a requester may change or drop them mid-cycle.
      if (dev_win) begin
        mem_en    <= 1'b1;
        mem_we    <= dev_we;
        mem_addr  <= dev_addr;
        mem_wdata <= dev_wdata;
        grant_dev <= 1'b1;
      end else if (cpu_win) begin
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        grant_dev <= 1'b0;
      end

      if (txn_done || txn_abort) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (state == BUSY_DEV) begin
          dev_ready <= 1'b1;
          if (txn_abort)    dev_rdata <= 32'h0;
          else if (!mem_we) dev_rdata <= mem_rdata;
        end else begin
          MIO_ready <= 1'b1;
          if (txn_abort)    cpu_rdata <= 32'h0;
          else if (!mem_we) cpu_rdata <= mem_rdata;
        end
      end

      if (state == RESP) grant_dev <= 1'b0;
    end
  end

  // Counts IDLE arbitrations the device loses to the CPU; saturation forces the next device win.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (dev_win) begin
      wait_cnt <= '0;
    end else if (cpu_win && dev_req && !wait_sat) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef MIO_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (cpu_win || dev_win) tmo_cnt <= '0;
      else if (state == BUSY_CPU || state == BUSY_DEV) tmo_cnt <= tmo_cnt + 1'b1;
      if (txn_abort) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  a_ready_exclusive: assert property (@(posedge clk) disable iff (reset) !(MIO_ready && dev_ready));
  a_no_en_in_resp:   assert property (@(posedge clk) disable iff (reset) (state == RESP) |-> !mem_en);

endmodule
